imem_loader: RTL and testbench

Writer-side companion to the byte-addressed, big-endian, read-only instruction memory (16 KiB; fetch reads {mem[PC],mem[PC+1],mem[PC+2],mem[PC+3]}).
- Accepts 32-bit instruction words over a valid/ready stream.
- Writes each word as four sequential byte writes to the memory's byte write port, starting at a programmed base address.
- Lets test programs be loaded at run time instead of only from initial blocks.

---
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory write port, MSB first.
// Optional build macro IMEM_LOADER_CSUM_EN adds a running XOR checksum of written words on csum.
module imem_loader #(
    parameter int MEM_BYTES = 16384,
    parameter int CNT_W     = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [31:0]      in_word,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      csum
);

    // state     | meaning
    // IDLE      | waiting for start
    // WAIT_WORD | in_ready high, waiting for the next word handshake
    // WRITE     | four byte writes of the latched word, MSB first
    // FINISH    | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, FINISH} state_t;

    state_t           state;
    logic [31:0]      addr;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      word;
    logic [1:0]       beat;
    logic             handshake;
    logic             range_bad;

    assign in_ready  = (state == WAIT_WORD);
    assign handshake = in_valid && in_ready;
    // 33-bit sum so an address near 2^32 cannot wrap past the check
    assign range_bad = ({1'b0, addr} + 33'd3) >= 33'(MEM_BYTES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            beat      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (base_addr[1:0] != 2'b00) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else if (word_count == '0) begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            addr      <= base_addr;
                            remaining <= word_count;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            state     <= WAIT_WORD;
                        end
                    end
                end
                WAIT_WORD: begin
                    if (handshake) begin
                        if (range_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            word      <= in_word;
                            beat      <= 2'd0;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= in_word[31:24];
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (beat == 2'd3) begin
                        mem_we    <= 1'b0;
                        addr      <= addr + 32'd4;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            state <= WAIT_WORD;
                        end
                    end else begin
                        // word shifts left so the next byte is always at [23:16]
                        beat      <= beat + 2'd1;
                        mem_addr  <= mem_addr + 32'd1;
                        mem_wdata <= word[23:16];
                        word      <= {word[23:0], 8'h00};
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    logic start_take;
    logic word_take;

    assign start_take = (state == IDLE) && start && (base_addr[1:0] == 2'b00);
    assign word_take  = handshake && !range_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (start_take) begin
            csum <= '0;
        end else if (word_take) begin
            csum <= csum ^ in_word;
        end
    end
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against a byte-write list model.
module tb_imem_loader;
    localparam int MEM_BYTES = 16384;
    localparam int CNT_W     = 12;

    logic             clk;
    logic             reset;
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_count;
    logic             in_valid;
    logic [31:0]      in_word;
    logic             in_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      csum;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .csum(csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [39:0] wr_q[$];
    int          wr_cyc[$];
    logic [39:0] exp_q[$];
    int          done_cnt;
    int          done_cyc;
    bit          busy_seen;
    int          viol;
    logic [31:0] wbuf[0:15];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_wdata});
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_seen = 1'b1;
        if (mem_we && in_ready) viol++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        wr_cyc.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        busy_seen = 1'b0;
        viol      = 0;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) chk("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic do_load(input logic [31:0] base, input int count, input bit poke);
        logic [31:0] exp_csum = '0;
        bit          exp_err  = 1'b0;
        int          nsend    = 0;
        bit          ok;
        int          n;

        clear_mon();
        exp_q.delete();
        if (base[1:0] != 2'b00) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < count; i++) begin
                longint a = longint'(base) + 4 * i;
                nsend++;
                if (a + 3 >= MEM_BYTES) begin
                    exp_err = 1'b1;
                    break;
                end
                for (int b = 0; b < 4; b++)
                    exp_q.push_back({32'(a + b), 8'((wbuf[i] >> (24 - 8 * b)) & 32'hff)});
                exp_csum ^= wbuf[i];
            end
        end

        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = CNT_W'(count);
        @(negedge clk);
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = CNT_W'($urandom);

        for (int i = 0; i < nsend; i++) begin
            int gap = $urandom_range(0, 3);
            in_valid = 1'b0;
            if (poke && i == 1) begin
                wait_ready(ok);
                start      = 1'b1;
                base_addr  = 32'd400;
                word_count = CNT_W'(5);
                @(negedge clk);
                start = 1'b0;
                gap   = 2;
            end
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_word  = wbuf[i];
            wait_ready(ok);
            if (!ok) break;
            @(negedge clk);
            in_valid = 1'b0;
            in_word  = $urandom;
        end

        n = 0;
        while (done_cnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);

        chk("n_writes", 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk($sformatf("write[%0d]", i), 64'(wr_q[i]), 64'(exp_q[i]));
        for (int k = 0; k + 3 < wr_cyc.size(); k += 4)
            chk("beats_consecutive", 64'(wr_cyc[k + 3] - wr_cyc[k]), 64'd3);
        if (!exp_err && wr_cyc.size() > 0)
            chk("done_latency", 64'(done_cyc), 64'(wr_cyc[wr_cyc.size() - 1] + 1));
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("err", 64'(err), 64'(exp_err));
        chk("ready_during_write", 64'(viol), 64'd0);
        chk("busy_seen", 64'(busy_seen), 64'(base[1:0] == 2'b00));
        chk("idle_after", 64'({busy, done, mem_we}), 64'd0);
`ifdef IMEM_LOADER_CSUM_EN
        if (base[1:0] == 2'b00) chk("csum", 64'(csum), 64'(exp_csum));
`else
        chk("csum_tied", 64'(csum), 64'(exp_csum & 32'h0));
`endif
    endtask

    initial begin
        bit ok;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b0;
        in_word    = '0;
        clear_mon();
        #12;
        chk("reset_outputs", 64'({in_ready, mem_we, busy, done, err}), 64'd0);
        chk("reset_buses", 64'({mem_addr, mem_wdata}), 64'd0);
        chk("reset_csum", 64'(csum), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        wbuf[0] = 32'h24130005;
        do_load(32'd200, 1, 1'b0);

        wbuf[0] = 32'h0E74B820;
        wbuf[1] = 32'h0E75C024;
        do_load(32'd216, 2, 1'b1);

        do_load(32'd0, 0, 1'b0);
        do_load(32'h66, 1, 1'b0);

        wbuf[0] = $urandom;
        wbuf[1] = $urandom;
        do_load(32'd16380, 2, 1'b0);

        // reset during beat 1 of a load
        clear_mon();
        @(negedge clk);
        start      = 1'b1;
        base_addr  = 32'd0;
        word_count = CNT_W'(1);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_word  = $urandom;
        wait_ready(ok);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_reset_beat0", 64'(mem_we), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_flags", 64'({in_ready, mem_we, busy, done, err}), 64'd0);
        chk("mid_reset_buses", 64'({mem_addr, mem_wdata}), 64'd0);
        chk("mid_reset_csum", 64'(csum), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        do_load(32'd0, 3, 1'b0);

        for (int t = 0; t < 8; t++) begin
            logic [31:0] base;
            int cnt = $urandom_range(1, 6);
            if ($urandom_range(0, 2) == 0)
                base = 32'(MEM_BYTES - 4 * $urandom_range(1, 6));
            else
                base = 32'($urandom_range(0, MEM_BYTES / 4 - 8) * 4);
            for (int i = 0; i < cnt; i++) wbuf[i] = $urandom;
            do_load(base, cnt, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
